// File: rtl/sr_debug_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sr_debug_ctrl: run/halt/step/dump sequencer gating the sr_cpu core.
// Optional macro SR_DEBUG_CYCLE_CNT_EN adds a retired-cycle counter dump beat.
// Revision: 1.0
// ----------------------------------------------------------------------------
module sr_debug_ctrl #(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  output logic              cpu_en,
  input  logic [31:0]       pc,
  output logic [4:0]        dbg_addr,
  input  logic [31:0]       dbg_data,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic              dump_last,
  output logic              halted
);

  localparam logic [1:0] OP_RUN  = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  localparam logic [STEP_W-1:0] STEP_ZERO = '0;
  localparam logic [STEP_W-1:0] STEP_ONE  = {{(STEP_W-1){1'b0}}, 1'b1};

`ifdef SR_DEBUG_CYCLE_CNT_EN
  localparam logic [5:0] LAST_BEAT = 6'd32;
`else
  localparam logic [5:0] LAST_BEAT = 6'd31;
`endif

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DUMP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               skip_q, skip_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [5:0]         beat_q, beat_d;
  logic               dump_valid_q, dump_valid_d;
  logic [31:0]        dump_data_q, dump_data_d;
  logic               dump_last_q, dump_last_d;

  logic               cmd_fire;
  logic               halt_req;
  logic               bp_hit;
  logic [31:0]        beat_value;

`ifdef SR_DEBUG_CYCLE_CNT_EN
  logic [31:0]        cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + {31'd0, cpu_en};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= 32'd0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end
`endif

  // Decoded outputs: they must react in the same cycle as a breakpoint or HALT.
  always_comb begin
    cmd_ready = (state_q == ST_HALT) || (state_q == ST_RUN);
    halted    = (state_q == ST_HALT);
    cmd_fire  = cmd_valid && cmd_ready;
    halt_req  = cmd_fire && (cmd_op == OP_HALT);
    bp_hit    = bp_en && !skip_q && (pc == bp_addr);
    cpu_en    = 1'b0;
    unique case (state_q)
      ST_RUN:  cpu_en = !(bp_hit || halt_req);
      ST_STEP: cpu_en = 1'b1;
      default: cpu_en = 1'b0;
    endcase
  end

  always_comb begin
    beat_value = dbg_data;
`ifdef SR_DEBUG_CYCLE_CNT_EN
    if (beat_q == 6'd32) begin
      beat_value = cyc_cnt_q;
    end
`endif
  end

  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    step_cnt_d   = step_cnt_q;
    beat_d       = beat_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_last_d  = dump_last_q;

    unique case (state_q)
      ST_HALT: begin
        if (cmd_fire) begin
          unique case (cmd_op)
            OP_RUN: begin
              state_d = ST_RUN;
              skip_d  = 1'b1;
            end
            OP_STEP: begin
              state_d    = ST_STEP;
              step_cnt_d = (cmd_arg == STEP_ZERO) ? STEP_ONE : cmd_arg;
            end
            OP_DUMP: begin
              state_d = ST_DUMP;
              beat_d  = 6'd0;
            end
            default: begin
              state_d = ST_HALT;
            end
          endcase
        end
      end

      ST_RUN: begin
        skip_d = 1'b0;
        if (!cpu_en) begin
          state_d = ST_HALT;
        end
      end

      ST_STEP: begin
        step_cnt_d = step_cnt_q - STEP_ONE;
        if (step_cnt_q == STEP_ONE) begin
          state_d = ST_HALT;
        end
      end

      ST_DUMP: begin
        if (dump_valid_q && dump_ready && dump_last_q) begin
          dump_valid_d = 1'b0;
          dump_last_d  = 1'b0;
          beat_d       = 6'd0;
          state_d      = ST_HALT;
        end else if ((!dump_valid_q || dump_ready) && (beat_q <= LAST_BEAT)) begin
          // Output register empty or draining: load the beat addressed now.
          dump_valid_d = 1'b1;
          dump_data_d  = beat_value;
          dump_last_d  = (beat_q == LAST_BEAT);
          beat_d       = beat_q + 6'd1;
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HALT;
      skip_q       <= 1'b0;
      step_cnt_q   <= STEP_ZERO;
      beat_q       <= 6'd0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= 32'd0;
      dump_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      step_cnt_q   <= step_cnt_d;
      beat_q       <= beat_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_last_q  <= dump_last_d;
    end
  end

  assign dbg_addr   = beat_q[4:0];
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_debug_ctrl.sv
`default_nettype none
// Bench for sr_debug_ctrl: test-plan scenarios plus random traffic, checked every
// cycle against a transaction-level model (mode, step budget, dump beat queue).
module tb_sr_debug_ctrl;

  localparam int STEP_W = 16;
`ifdef SR_DEBUG_CYCLE_CNT_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif
  localparam logic [1:0] OP_RUN  = 2'd0;
  localparam logic [1:0] OP_HALT = 2'd1;
  localparam logic [1:0] OP_STEP = 2'd2;
  localparam logic [1:0] OP_DUMP = 2'd3;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_DUMP = 3;
  localparam int CAPN = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [STEP_W-1:0] cmd_arg = '0;
  logic              cpu_en;
  logic [31:0]       pc;
  logic [4:0]        dbg_addr;
  logic [31:0]       dbg_data;
  logic              bp_en = 1'b0;
  logic [31:0]       bp_addr = 32'd0;
  logic              dump_valid;
  logic              dump_ready = 1'b0;
  logic [31:0]       dump_data;
  logic              dump_last;
  logic              halted;

  sr_debug_ctrl #(.STEP_W(STEP_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .cpu_en(cpu_en), .pc(pc), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .bp_en(bp_en), .bp_addr(bp_addr),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_last(dump_last), .halted(halted)
  );

  always #5 clk = ~clk;

  // CPU stand-in: sequential code looping over 0x00..0x3C, random register writes.
  logic [31:0] cpu_pc = 32'd0;
  logic [31:0] regs [32] = '{default: 32'h0};
  logic        poke_pc_en = 1'b0;
  logic [31:0] poke_pc_val = 32'd0;
  logic        poke_reg_en = 1'b0;
  logic [4:0]  poke_idx = 5'd0;
  logic [31:0] poke_val = 32'd0;

  assign pc       = cpu_pc;
  assign dbg_data = (dbg_addr == 5'd0) ? cpu_pc : regs[dbg_addr];

  always @(posedge clk) begin
    if (rst) cpu_pc <= 32'd0;
    else if (poke_pc_en) cpu_pc <= poke_pc_val;
    else if (cpu_en) cpu_pc <= (cpu_pc + 32'd4) & 32'h3C;
    if (poke_reg_en) regs[poke_idx] <= poke_val;
    else if (!rst && cpu_en) regs[5'($urandom_range(31, 1))] <= $urandom;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model state
  bit          m_on = 1'b0;
  int          m_mode = M_HALT;
  bit          m_first = 1'b0;
  bit          m_stream = 1'b0;
  int unsigned m_steps = 0;
  logic [31:0] m_cyc = 32'd0;
  logic [32:0] m_q [$];

  // Observation records
  int          cyc_no = 0;
  int          en_cnt = 0;
  int          ncap = 0;
  bit          cap_on = 1'b0;
  logic [31:0] cap_data [CAPN];
  logic        cap_last [CAPN];
  int          cap_cyc  [CAPN];

  task automatic model_reset();
    m_mode = M_HALT; m_first = 1'b0; m_stream = 1'b0; m_steps = 0; m_cyc = 32'd0;
    m_q.delete();
  endtask

  task automatic model_cycle();
    bit exp_ready, fire, exp_en, exp_valid;
    logic [32:0] head;
    exp_ready = (m_mode == M_HALT) || (m_mode == M_RUN);
    fire      = cmd_valid && exp_ready;
    exp_en    = 1'b0;
    if (m_mode == M_STEP) exp_en = 1'b1;
    if (m_mode == M_RUN)
      exp_en = !(fire && cmd_op == OP_HALT) && !(bp_en && !m_first && cpu_pc == bp_addr);
    exp_valid = (m_mode == M_DUMP) && m_stream && (m_q.size() > 0);

    check("cpu_en", 32'(cpu_en), 32'(exp_en));
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    check("halted", 32'(halted), 32'(m_mode == M_HALT));
    check("dump_valid", 32'(dump_valid), 32'(exp_valid));
    if (exp_valid) begin
      head = m_q[0];
      check("dump_data", dump_data, head[31:0]);
      check("dump_last", 32'(dump_last), 32'(head[32]));
    end

    if (exp_en) m_cyc = m_cyc + 32'd1;
    case (m_mode)
      M_HALT: if (fire) begin
        if (cmd_op == OP_RUN) begin
          m_mode = M_RUN; m_first = 1'b1;
        end else if (cmd_op == OP_STEP) begin
          m_mode = M_STEP; m_steps = (cmd_arg == '0) ? 1 : int'(cmd_arg);
        end else if (cmd_op == OP_DUMP) begin
          m_mode = M_DUMP; m_stream = 1'b0; m_q.delete();
          for (int k = 0; k < NB; k++) begin
            logic [31:0] v;
            if (k == 0) v = cpu_pc;
            else if (k < 32) v = regs[k];
            else v = m_cyc;
            m_q.push_back({(k == NB - 1), v});
          end
        end
      end
      M_RUN: begin
        m_first = 1'b0;
        if (!exp_en) m_mode = M_HALT;
      end
      M_STEP: begin
        m_steps--;
        if (m_steps == 0) m_mode = M_HALT;
      end
      default: begin
        if (!m_stream) m_stream = 1'b1;
        else if (dump_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_mode = M_HALT; m_stream = 1'b0; end
        end
      end
    endcase
  endtask

  // Compare process: outputs are sampled mid-cycle, model advances by one clock.
  initial begin
    forever begin
      @(negedge clk);
      cyc_no++;
      if (cpu_en === 1'b1) en_cnt++;
      if (cap_on && dump_valid === 1'b1 && dump_ready) begin
        cap_data[ncap] = dump_data;
        cap_last[ncap] = dump_last;
        cap_cyc[ncap]  = cyc_no;
        if (ncap < CAPN - 1) ncap++;
      end
      if (m_on) model_cycle();
      if (rst) begin
        model_reset();
        m_on = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [STEP_W-1:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_halted(input int max, output int n);
    n = 0;
    while (halted !== 1'b1 && n < max) begin tick(); n++; end
    check("halt_timeout", 32'(halted), 32'd1);
  endtask

  task automatic poke_pc(input logic [31:0] v);
    poke_pc_en = 1'b1; poke_pc_val = v;
    tick();
    poke_pc_en = 1'b0;
  endtask

  initial begin
    int n, e0, base, base1, mism, nlast;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_dbg_addr", 32'(dbg_addr), 32'd0);
    check("rst_dump_data", dump_data, 32'd0);
    check("rst_dump_last", 32'(dump_last), 32'd0);
    for (int i = 0; i < 5; i++) begin
      check("idle_halted", 32'(halted), 32'd1);
      check("idle_cpu_en", 32'(cpu_en), 32'd0);
      check("idle_dump_valid", 32'(dump_valid), 32'd0);
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      tick();
    end

    // STEP 3, STEP 0, STEP max
    e0 = en_cnt; send(OP_STEP, 16'd3); wait_halted(20, n);
    check("step3_cycles", 32'(n), 32'd3);
    check("step3_en", 32'(en_cnt - e0), 32'd3);
    e0 = en_cnt; send(OP_STEP, 16'd0); wait_halted(20, n);
    check("step0_en", 32'(en_cnt - e0), 32'd1);
    e0 = en_cnt; send(OP_STEP, 16'hFFFF); wait_halted(70000, n);
    check("stepmax_en", 32'(en_cnt - e0), 32'd65535);

    // Breakpoint at 0x10 from pc=0, then re-run from the breakpoint
    poke_pc(32'd0);
    bp_en = 1'b1; bp_addr = 32'h10;
    e0 = en_cnt; send(OP_RUN, '0); wait_halted(100, n);
    check("bp1_pc", cpu_pc, 32'h10);
    check("bp1_en", 32'(en_cnt - e0), 32'd4);
    e0 = en_cnt; send(OP_RUN, '0); wait_halted(100, n);
    check("bp2_pc", cpu_pc, 32'h10);
    check("bp2_en", 32'(en_cnt - e0), 32'd16);
    bp_en = 1'b0;

    // Full-rate dump
    poke_pc(32'h20);
    poke_reg_en = 1'b1; poke_idx = 5'd5; poke_val = 32'hDEADBEEF; tick(); poke_reg_en = 1'b0;
    cap_on = 1'b1; dump_ready = 1'b1;
    base1 = ncap; send(OP_DUMP, '0); wait_halted(200, n);
    check("dump1_beats", 32'(ncap - base1), 32'(NB));
    check("dump1_beat0", cap_data[base1], 32'h20);
    check("dump1_beat5", cap_data[base1 + 5], 32'hDEADBEEF);
    check("dump1_rate", 32'(cap_cyc[base1 + NB - 1] - cap_cyc[base1]), 32'(NB - 1));
    nlast = 0;
    for (int i = 0; i < NB; i++) if (cap_last[base1 + i] === 1'b1) nlast++;
    check("dump1_last_count", 32'(nlast), 32'd1);
    check("dump1_last_pos", 32'(cap_last[base1 + NB - 1]), 32'd1);

    // Stalled dump must reproduce the same beats
    base = ncap; dump_ready = 1'b0; send(OP_DUMP, '0); n = 0;
    while (halted !== 1'b1 && n < 300) begin dump_ready = ~dump_ready; tick(); n++; end
    check("dump2_timeout", 32'(halted), 32'd1);
    check("dump2_beats", 32'(ncap - base), 32'(NB));
    check("dump2_beat5", cap_data[base + 5], 32'hDEADBEEF);
    mism = 0;
    for (int i = 0; i < NB; i++)
      if (cap_data[base + i] !== cap_data[base1 + i] || cap_last[base + i] !== cap_last[base1 + i]) mism++;
    check("dump2_vs_dump1", 32'(mism), 32'd0);

    // Reset during beat 10, then a fresh dump
    base = ncap; dump_ready = 1'b1; send(OP_DUMP, '0); n = 0;
    while (ncap - base < 10 && n < 100) begin tick(); n++; end
    check("rstdump_reach", 32'(ncap - base), 32'd10);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstdump_valid", 32'(dump_valid), 32'd0);
    check("rstdump_halted", 32'(halted), 32'd1);
    base = ncap; send(OP_DUMP, '0); wait_halted(200, n);
    check("dump3_beats", 32'(ncap - base), 32'(NB));
    check("dump3_beat0", cap_data[base], 32'd0);

    // STEP 7 then DUMP
    rst = 1'b1; tick(); rst = 1'b0;
    send(OP_STEP, 16'd7); wait_halted(20, n);
    base = ncap; send(OP_DUMP, '0); wait_halted(200, n);
    check("dump4_beats", 32'(ncap - base), 32'(NB));
    check("dump4_last_pos", 32'(cap_last[base + NB - 1]), 32'd1);
    check("dump4_beat0", cap_data[base], 32'h1C);
`ifdef SR_DEBUG_CYCLE_CNT_EN
    check("dump4_cycle_cnt", cap_data[base + 32], 32'd7);
`endif
    cap_on = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = ($urandom_range(3) == 0);
      cmd_op = 2'($urandom_range(3));
      cmd_arg = ($urandom_range(9) == 0) ? 16'd0 : 16'($urandom_range(6));
      if ($urandom_range(31) == 0) bp_en = ~bp_en;
      if ($urandom_range(15) == 0) bp_addr = {26'd0, 4'($urandom_range(15)), 2'b00};
      dump_ready = ($urandom_range(2) != 0);
      rst = ($urandom_range(400) == 0);
      tick();
    end
    cmd_valid = 1'b0; rst = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
